// File: rtl/spi_bus_arbiter.sv
// Byte-level arbiter sharing one spi_send_receive engine between the EEPROM
// loader (client 0) and the HC595/stepper path (client 1), with burst lock and stall timeout.
module spi_bus_arbiter #(
  parameter int CS_GAP  = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req0,
  input  logic       lock0,
  input  logic [7:0] tx0,
  input  logic       req1,
  input  logic       lock1,
  input  logic [7:0] tx1,
  output logic [1:0] gnt,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rx_byte,
  output logic       cs0_n,
  output logic       cs1_n,
  output logic       err,
  output logic       eng_send_request,
  output logic [7:0] eng_din,
  output logic       eng_cs_at_end,
  input  logic       eng_processing,
  input  logic       eng_data_valid,
  input  logic [7:0] eng_dout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;

  // Terminal counts: a wait aborts once TIMEOUT cycles have elapsed; GAP lasts CS_GAP cycles.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  logic [2:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             cs0_n_q, cs0_n_d;
  logic             cs1_n_q, cs1_n_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err_q, err_d;
  logic             send_req_q, send_req_d;
  logic [7:0]       din_q, din_d;
  logic [7:0]       rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dv_q;

  logic       own_req;
  logic       own_lock;
  logic [7:0] own_tx;
  logic       pick;
  logic       dv_rise;
  logic       go_start;
  logic       go_release;

  assign own_req  = owner_q ? req1 : req0;
  assign own_lock = owner_q ? lock1 : lock0;
  assign pick     = (req0 & req1) ? ~last_owner_q : req1;
  assign dv_rise  = eng_data_valid & ~dv_q;
  assign own_tx   = owner_d ? tx1 : tx0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    cs0_n_d      = cs0_n_q;
    cs1_n_d      = cs1_n_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    send_req_d   = 1'b0;
    din_d        = din_q;
    rx_d         = rx_q;
    cnt_d        = cnt_q;
    go_start     = 1'b0;
    go_release   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          owner_d  = pick;
          gnt_d    = pick ? 2'b10 : 2'b01;
          cs0_n_d  = pick;
          cs1_n_d  = ~pick;
          go_start = 1'b1;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (eng_processing) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          go_release = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_DONE: begin
        if (dv_rise) begin
          rx_d    = eng_dout;
          done0_d = ~owner_q;
          done1_d = owner_q;
          if (own_lock && own_req) go_start = 1'b1;
          else if (own_lock)       state_d = S_HOLD;
          else                     go_release = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          go_release = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        // The other client is deliberately starved while the owner keeps its lock.
        if (own_req)        go_start = 1'b1;
        else if (!own_lock) go_release = 1'b1;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d = cnt_q + CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase

    // The byte is latched on entry so eng_din is already valid while send_request is high.
    if (go_start) begin
      state_d    = S_START;
      send_req_d = 1'b1;
      din_d      = own_tx;
    end
    if (go_release) begin
      state_d      = S_GAP;
      gnt_d        = 2'b00;
      cs0_n_d      = 1'b1;
      cs1_n_d      = 1'b1;
      last_owner_d = owner_q;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
      cs0_n_q      <= 1'b1;
      cs1_n_q      <= 1'b1;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
      send_req_q   <= 1'b0;
      din_q        <= 8'h00;
      rx_q         <= 8'h00;
      cnt_q        <= '0;
      dv_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      cs0_n_q      <= cs0_n_d;
      cs1_n_q      <= cs1_n_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
      send_req_q   <= send_req_d;
      din_q        <= din_d;
      rx_q         <= rx_d;
      cnt_q        <= cnt_d;
      dv_q         <= eng_data_valid;
    end
  end

  assign gnt              = gnt_q;
  assign done0            = done0_q;
  assign done1            = done1_q;
  assign rx_byte          = rx_q;
  assign cs0_n            = cs0_n_q;
  assign cs1_n            = cs1_n_q;
  assign err              = err_q;
  assign eng_send_request = send_req_q;
  assign eng_din          = din_q;
  assign eng_cs_at_end    = 1'b0;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: a behavioural engine model answers each
// start request, and expected start/done events are queued and compared as they occur.
module tb_spi_bus_arbiter;

  typedef struct packed {
    logic       who;
    logic [7:0] data;
  } xfer_t;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
  logic [1:0] gnt;
  logic       done0, done1, cs0_n, cs1_n, err;
  logic [7:0] rx_byte;
  logic       eng_send_request, eng_cs_at_end;
  logic [7:0] eng_din;
  logic       eng_processing, eng_data_valid;
  logic [7:0] eng_dout;

  xfer_t      exp_tx_q[$];
  xfer_t      exp_rx_q[$];
  logic [7:0] eng_resp_q[$];
  xfer_t      mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cs_hi_seen = 0;
  bit         eng_stall = 1'b0;
  int         eng_cnt;
  bit         eng_busy;

  spi_bus_arbiter #(.CS_GAP(2), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .nreset(nreset),
    .req0(req0), .lock0(lock0), .tx0(tx0),
    .req1(req1), .lock1(lock1), .tx1(tx1),
    .gnt(gnt), .done0(done0), .done1(done1), .rx_byte(rx_byte),
    .cs0_n(cs0_n), .cs1_n(cs1_n), .err(err),
    .eng_send_request(eng_send_request), .eng_din(eng_din), .eng_cs_at_end(eng_cs_at_end),
    .eng_processing(eng_processing), .eng_data_valid(eng_data_valid), .eng_dout(eng_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_byte(input logic who, input logic [7:0] tx, input logic [7:0] rx);
    exp_tx_q.push_back({who, tx});
    exp_rx_q.push_back({who, rx});
    eng_resp_q.push_back(rx);
  endtask

  // Engine model: processing high for 9 cycles after a start, then a 1-cycle data_valid.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      eng_processing <= 1'b0;
      eng_data_valid <= 1'b0;
      eng_dout       <= 8'h00;
      eng_busy       <= 1'b0;
      eng_cnt        <= 0;
    end else begin
      eng_data_valid <= 1'b0;
      if (!eng_busy) begin
        if (eng_send_request && !eng_stall) begin
          eng_busy       <= 1'b1;
          eng_cnt        <= 0;
          eng_processing <= 1'b1;
        end
      end else if (eng_cnt == 8) begin
        eng_busy       <= 1'b0;
        eng_processing <= 1'b0;
        eng_data_valid <= 1'b1;
        if (eng_resp_q.size() != 0) eng_dout <= eng_resp_q.pop_front();
        else                        eng_dout <= 8'hEE;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  // Scoreboard monitor: every start and every done must match the next queued expectation.
  always @(negedge clk) begin
    if (nreset) begin
      if (eng_send_request) begin
        if (exp_tx_q.size() == 0) check("start_unexpected", 1, 0);
        else begin
          mon_e = exp_tx_q.pop_front();
          check("start_gnt", gnt, mon_e.who ? 2'b10 : 2'b01);
          check("start_din", eng_din, mon_e.data);
        end
      end
      if (done0 | done1) begin
        if (exp_rx_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          mon_e = exp_rx_q.pop_front();
          check("done_client", {done1, done0}, mon_e.who ? 2'b10 : 2'b01);
          check("rx_byte", rx_byte, mon_e.data);
        end
      end
    end
  end

  task automatic wait_start(input int budget, input string tag);
    int n = 0;
    while (!eng_send_request && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, eng_send_request, 1);
  endtask

  // Advances at least one cycle; counts owner chip-select-high cycles seen before done.
  task automatic wait_done(input logic who, input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!(who ? done1 : done0)) cs_hi_seen += int'(who ? cs1_n : cs0_n);
    end while (!(who ? done1 : done0) && n < budget);
    check(tag, who ? done1 : done0, 1);
  endtask

  task automatic reset_dut();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] burst [4];
    int n;
    int bad;
    burst[0] = 8'h03; burst[1] = 8'h00; burst[2] = 8'h11; burst[3] = 8'h22;

    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_cs0", cs0_n, 1);
    check("rst_cs1", cs1_n, 1);
    check("rst_done", {done1, done0}, 2'b00);
    check("rst_err", err, 0);
    check("rst_sreq", eng_send_request, 0);
    check("rst_din", eng_din, 8'h00);
    check("rst_rx", rx_byte, 8'h00);
    check("cs_at_end", eng_cs_at_end, 0);
    nreset = 1'b1;
    @(negedge clk);

    // Single byte, client 0
    expect_byte(1'b0, 8'h03, 8'h5A);
    tx0 = 8'h03; lock0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check("t1_gnt", gnt, 2'b01);
    check("t1_cs0_low", cs0_n, 0);
    check("t1_cs1_high", cs1_n, 1);
    check("t1_sreq", eng_send_request, 1);
    cs_hi_seen = 0;
    wait_done(1'b0, 40, "t1_done");
    req0 = 1'b0;
    check("t1_cs_run", cs_hi_seen, 0);
    check("t1_gap_gnt", gnt, 2'b00);
    check("t1_gap_cs0", cs0_n, 1);
    @(negedge clk);
    check("t1_gap2_cs0", cs0_n, 1);
    check("t1_gap2_gnt", gnt, 2'b00);
    repeat (3) @(negedge clk);

    // Locked burst, client 0
    for (int i = 0; i < 4; i++) expect_byte(1'b0, burst[i], 8'hC0 + 8'(i));
    tx0 = burst[0]; lock0 = 1'b1; req0 = 1'b1;
    cs_hi_seen = 0;
    for (int i = 0; i < 4; i++) begin
      wait_start(10, "t2_start");
      if (i < 3) tx0 = burst[i+1];
      else       lock0 = 1'b0;
      wait_done(1'b0, 40, "t2_done");
      if (i < 3) check("t2_no_gap_cs0", cs0_n, 0);
    end
    req0 = 1'b0;
    check("t2_cs_run", cs_hi_seen, 0);
    check("t2_release_cs0", cs0_n, 1);
    check("t2_release_gnt", gnt, 2'b00);
    repeat (4) @(negedge clk);

    // Round-robin from reset: 0,1,0,1
    reset_dut();
    expect_byte(1'b0, 8'h40, 8'h90);
    expect_byte(1'b1, 8'h41, 8'h91);
    expect_byte(1'b0, 8'h40, 8'h92);
    expect_byte(1'b1, 8'h41, 8'h93);
    tx0 = 8'h40; tx1 = 8'h41; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(done0 | done1) && n < 40);
      check("t3_done", done0 | done1, 1);
      check("t3_order", done1, i % 2);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);

    // HOLD: client 1 keeps the bus while client 0 waits
    expect_byte(1'b1, 8'h77, 8'hB1);
    expect_byte(1'b0, 8'h55, 8'hB2);
    tx1 = 8'h77; lock1 = 1'b1; req1 = 1'b1;
    wait_start(10, "t4_start");
    req1 = 1'b0; tx0 = 8'h55; req0 = 1'b1;
    wait_done(1'b1, 40, "t4_done1");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt !== 2'b10 || cs1_n !== 1'b0 || cs0_n !== 1'b1 || eng_send_request !== 1'b0) bad++;
    end
    check("t4_hold", bad, 0);
    lock1 = 1'b0;
    @(negedge clk);
    check("t4_gap_gnt", gnt, 2'b00);
    n = 0;
    while (gnt !== 2'b01 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_regrant", gnt, 2'b01);
    wait_done(1'b0, 40, "t4_done0");
    req0 = 1'b0;
    repeat (4) @(negedge clk);

    // Timeout: engine never answers
    eng_stall = 1'b1;
    exp_tx_q.push_back({1'b0, 8'h99});
    tx0 = 8'h99; req0 = 1'b1;
    wait_start(10, "t5_start");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 40);
    check("t5_err_latency", n, 17);
    check("t5_gnt_released", gnt, 2'b00);
    check("t5_cs0_released", cs0_n, 1);
    req0 = 1'b0; eng_stall = 1'b0;
    @(negedge clk);
    check("t5_err_pulse", err, 0);
    repeat (3) @(negedge clk);
    expect_byte(1'b0, 8'h5C, 8'hD4);
    tx0 = 8'h5C; req0 = 1'b1;
    wait_done(1'b0, 40, "t5_retry_done");
    req0 = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-burst while the byte is in WAIT_DONE
    expect_byte(1'b0, 8'h31, 8'h66);
    tx0 = 8'h31; lock0 = 1'b1; req0 = 1'b1;
    wait_start(10, "t6_start");
    n = 0;
    while (!eng_processing && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6_processing", eng_processing, 1);
    repeat (2) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    check("t6_gnt", gnt, 2'b00);
    check("t6_cs", {cs1_n, cs0_n}, 2'b11);
    check("t6_sreq", eng_send_request, 0);
    exp_rx_q.delete();
    eng_resp_q.delete();
    req0 = 1'b0; lock0 = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    expect_byte(1'b0, 8'h32, 8'h67);
    tx0 = 8'h32; req0 = 1'b1;
    wait_done(1'b0, 40, "t6_fresh_done");
    req0 = 1'b0;
    repeat (5) @(negedge clk);

    check("sb_tx_drained", exp_tx_q.size(), 0);
    check("sb_rx_drained", exp_rx_q.size(), 0);
    check("eng_resp_drained", eng_resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
